// File: rtl/biriscv_irq_ctrl.sv
// ----------------------------------------------------------------------------
// biriscv_irq_ctrl
// Machine-level interrupt source for the core. It holds a 64-bit mtime timer
// with an mtimecmp compare, a software-interrupt bit (MSIP), and a pending
// latch for an external interrupt line. The three sources drive the core's
// 32-bit interrupt vector.
//
// Optional build macro: IRQ_CTRL_EXT_SYNC_EN
//   defined   : ext_irq_i passes through a 2-flop synchronizer and then a
//               third flop. Level-mode latency to intr_o[11] is 4 cycles.
//   undefined : ext_irq_i is registered once, so the input must already be
//               synchronous to clk_i. Level-mode latency is 2 cycles.
//
// Parameters:
//   PRESCALE     mtime advances once every PRESCALE clocks (1..65535)
//   MTIME_RESET  reset value of mtime
//
// Ports:
//   clk_i, rst_i       clock; asynchronous active-high reset
//   req_valid_i        bus request strobe, one cycle per access
//   req_write_i        1 = write, 0 = read
//   req_addr_i[7:0]    byte address; bits [1:0] ignored
//   req_wdata_i[31:0]  write data
//   ack_o              response strobe, one cycle after the request
//   err_o              unmapped address, valid with ack_o
//   rdata_o[31:0]      read data, valid with ack_o, 0 otherwise
//   ext_irq_i          external interrupt line
//   intr_o[31:0]       interrupt vector: [3] MSIP, [7] MTIP, [11] MEIP
// ----------------------------------------------------------------------------
module biriscv_irq_ctrl #(
  parameter int unsigned PRESCALE    = 1,
  parameter logic [63:0] MTIME_RESET = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [7:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  input  logic        ext_irq_i,
  output logic [31:0] intr_o
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned WORD_W  = 6;

  localparam logic [PRESC_W-1:0] PRESCALE_MAX = PRESC_W'(PRESCALE - 1);

  // Word offsets (byte address [7:2])
  localparam logic [WORD_W-1:0] W_MSIP     = 6'd0;
  localparam logic [WORD_W-1:0] W_CMP_LO   = 6'd1;
  localparam logic [WORD_W-1:0] W_CMP_HI   = 6'd2;
  localparam logic [WORD_W-1:0] W_MTIME_LO = 6'd3;
  localparam logic [WORD_W-1:0] W_MTIME_HI = 6'd4;
  localparam logic [WORD_W-1:0] W_EXT_CTRL = 6'd5;
  localparam logic [WORD_W-1:0] W_EXT_PEND = 6'd6;

  // Architectural state
  logic [PRESC_W-1:0] presc_q;
  logic [63:0]        mtime_q;
  logic [63:0]        mtimecmp_q;
  logic               msip_q;
  logic               ext_en_q;
  logic               ext_edge_q;
  logic               ext_pend_q;
  logic               ext_s_q;

  // Registered interrupt sources feeding intr_o
  logic               msip_irq_q;
  logic               mtip_irq_q;
  logic               meip_irq_q;

  // Decode
  logic [WORD_W-1:0]  word_c;
  logic               hit_c;
  logic               wr_c;
  logic               wr_msip_c;
  logic               wr_cmp_lo_c;
  logic               wr_cmp_hi_c;
  logic               wr_mtime_lo_c;
  logic               wr_mtime_hi_c;
  logic               wr_ext_ctrl_c;
  logic               wr_ext_pend_c;
  logic [31:0]        rdata_c;

  logic               tick_c;
  logic               ext_in_c;
  logic               ext_rise_c;
  logic               ext_pend_c;
  logic               ext_mode_chg_c;

  // Byte-lane bits of the address carry no meaning for word registers
  logic               unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, req_addr_i[1:0]};

  // Address decode and per-register write strobes
  always_comb begin
    word_c        = req_addr_i[7:2];
    hit_c         = (word_c <= W_EXT_PEND);
    wr_c          = req_valid_i & req_write_i;
    wr_msip_c     = wr_c & (word_c == W_MSIP);
    wr_cmp_lo_c   = wr_c & (word_c == W_CMP_LO);
    wr_cmp_hi_c   = wr_c & (word_c == W_CMP_HI);
    wr_mtime_lo_c = wr_c & (word_c == W_MTIME_LO);
    wr_mtime_hi_c = wr_c & (word_c == W_MTIME_HI);
    wr_ext_ctrl_c = wr_c & (word_c == W_EXT_CTRL);
    wr_ext_pend_c = wr_c & (word_c == W_EXT_PEND);
  end

  // Read mux; unused register bits read as zero
  always_comb begin
    rdata_c = 32'd0;
    case (word_c)
      W_MSIP:     rdata_c = {31'd0, msip_q};
      W_CMP_LO:   rdata_c = mtimecmp_q[31:0];
      W_CMP_HI:   rdata_c = mtimecmp_q[63:32];
      W_MTIME_LO: rdata_c = mtime_q[31:0];
      W_MTIME_HI: rdata_c = mtime_q[63:32];
      W_EXT_CTRL: rdata_c = {30'd0, ext_edge_q, ext_en_q};
      W_EXT_PEND: rdata_c = {31'd0, ext_pend_c};
      default:    rdata_c = 32'd0;
    endcase
  end

  // Bus response: every request is accepted and answered on the next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o   <= req_valid_i;
      err_o   <= req_valid_i & ~hit_c;
      rdata_o <= (req_valid_i & ~req_write_i & hit_c) ? rdata_c : 32'd0;
    end
  end

  // Prescaler: mtime advances when the counter wraps at PRESCALE-1
  assign tick_c = (presc_q == PRESCALE_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (tick_c) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // mtime: a half-write overrides that cycle's increment; the other half
  // keeps its pre-increment value so no carry crosses into it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= MTIME_RESET;
    end else if (wr_mtime_lo_c) begin
      mtime_q[31:0] <= req_wdata_i;
    end else if (wr_mtime_hi_c) begin
      mtime_q[63:32] <= req_wdata_i;
    end else if (tick_c) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // mtimecmp and MSIP registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
    end else begin
      if (wr_cmp_lo_c) begin
        mtimecmp_q[31:0] <= req_wdata_i;
      end
      if (wr_cmp_hi_c) begin
        mtimecmp_q[63:32] <= req_wdata_i;
      end
      if (wr_msip_c) begin
        msip_q <= req_wdata_i[0];
      end
    end
  end

`ifdef IRQ_CTRL_EXT_SYNC_EN
  // Two-flop synchronizer ahead of the sampling flop
  logic ext_meta_q;
  logic ext_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
    end else begin
      ext_meta_q <= ext_irq_i;
      ext_sync_q <= ext_meta_q;
    end
  end

  assign ext_in_c = ext_sync_q;
`else
  assign ext_in_c = ext_irq_i;
`endif

  // Rising edge is seen on the same edge that ext_s_q captures the new 1,
  // so edge and level modes share the same latency to intr_o[11]
  assign ext_rise_c     = ext_in_c & ~ext_s_q;
  assign ext_pend_c     = ext_edge_q ? ext_pend_q : ext_s_q;
  assign ext_mode_chg_c = wr_ext_ctrl_c & (req_wdata_i[1] != ext_edge_q);

  // External interrupt control, sampling flop and edge-mode pending latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_s_q    <= 1'b0;
      ext_en_q   <= 1'b0;
      ext_edge_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      ext_s_q <= ext_in_c;
      if (wr_ext_ctrl_c) begin
        ext_en_q   <= req_wdata_i[0];
        ext_edge_q <= req_wdata_i[1];
      end
      // A new set beats a simultaneous W1C so no edge is lost
      if (ext_mode_chg_c) begin
        ext_pend_q <= 1'b0;
      end else if (ext_edge_q & ext_rise_c) begin
        ext_pend_q <= 1'b1;
      end else if (ext_edge_q & wr_ext_pend_c & req_wdata_i[0]) begin
        ext_pend_q <= 1'b0;
      end
    end
  end

  // Registered interrupt sources
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msip_irq_q <= 1'b0;
      mtip_irq_q <= 1'b0;
      meip_irq_q <= 1'b0;
    end else begin
      msip_irq_q <= msip_q;
      mtip_irq_q <= (mtime_q >= mtimecmp_q);
      meip_irq_q <= ext_pend_c & ext_en_q;
    end
  end

  assign intr_o = {20'd0, meip_irq_q, 3'd0, mtip_irq_q, 3'd0, msip_irq_q, 3'd0};

endmodule
